// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the GameBoy memory-port arbiter.
// Imported by the grant unit and the arbiter top.
package gb_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } bus_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int STARVE_W             = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;
    localparam logic [STARVE_W-1:0] STARVE_ONE = STARVE_W'(1);

endpackage

// File: rtl/gb_bus_grant.sv
// Grant decision between the pending CPU access and the DMA requester.
// Holds the starvation counter that bounds how long DMA may pre-empt the CPU.
module gb_bus_grant
    import gb_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int DMA_PRIO     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic cpu_pend,
    input  logic dma_req,
    output logic grant_valid,
    output logic grant_id
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dma_first;

    always_comb begin
        dma_first   = (DMA_PRIO != 0) && (starve_cnt < LIMIT);
        grant_valid = cpu_pend || dma_req;
        grant_id    = REQ_CPU;
        if (dma_req && (!cpu_pend || dma_first)) begin
            grant_id = REQ_DMA;
        end
    end

    // Only DMA grants that overtake a waiting CPU count towards starvation.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (enable && grant_valid) begin
            if (grant_id == REQ_CPU) begin
                starve_cnt <= '0;
            end else if (cpu_pend && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STARVE_ONE;
            end
        end
    end

endmodule

// File: rtl/gb_bus_arbiter.sv
// Shares one variable-latency memory port between the CPU bus and a DMA engine.
// The CPU is stalled through cpu_wait_n until its single access per strobe completes.
module gb_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int DMA_PRIO     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mreq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    output logic        cpu_wait_n,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_a,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    bus_state_t state;
    bus_state_t state_next;
    logic       cpu_strobe;
    logic       cpu_pend;
    logic       served;
    logic       grant_valid;
    logic       grant_id;

    assign cpu_strobe = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign cpu_pend   = cpu_strobe && !served;
    assign cpu_wait_n = !cpu_pend;

    gb_bus_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .DMA_PRIO     (DMA_PRIO)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .enable      (state == IDLE),
        .cpu_pend    (cpu_pend),
        .dma_req     (dma_req),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_id == REQ_DMA) ? DMA_ACC : CPU_ACC;
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One access per strobe: served blocks re-grant until the strobe drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            served <= 1'b0;
        end else if (!cpu_strobe) begin
            served <= 1'b0;
        end else if ((state == CPU_ACC) && mem_ack) begin
            served <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_wdata <= '0;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
            cpu_di    <= '0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req <= 1'b1;
                        if (grant_id == REQ_DMA) begin
                            mem_we    <= dma_we;
                            mem_a     <= dma_a;
                            mem_wdata <= dma_wdata;
                        end else begin
                            mem_we    <= !cpu_wr_n;
                            mem_a     <= cpu_a;
                            mem_wdata <= cpu_do;
                        end
                    end
                end
                CPU_ACC: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        // Data for an abandoned strobe is dropped.
                        if (cpu_strobe && !mem_we) begin
                            cpu_di <= mem_rdata;
                        end
                    end
                end
                DMA_ACC: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        dma_ack   <= 1'b1;
                        dma_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Directed self-checking bench for gb_bus_arbiter with a latency-programmable memory responder.
module tb_gb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mreq_n = 1'b1;
    logic        cpu_rd_n = 1'b1;
    logic        cpu_wr_n = 1'b1;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_do = '0;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n;
    logic        dma_req = 1'b0;
    logic        dma_we = 1'b0;
    logic [15:0] dma_a = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_a;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'hEE;

    int n_cmp = 0;
    int n_fail = 0;

    int          mem_lat = 0;
    logic        resp_en = 1'b1;
    logic        force_ack = 1'b0;
    int          acc_cnt = 0;
    int          wait_cnt = 0;
    logic        req_prev = 1'b0;
    logic        auto_ack;
    logic [15:0] log_a [0:63];
    logic        log_we [0:63];

    gb_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_a      (cpu_a),
        .cpu_do     (cpu_do),
        .cpu_di     (cpu_di),
        .cpu_wait_n (cpu_wait_n),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_a      (dma_a),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hB8;
    endfunction

    // Memory responder: acks mem_lat cycles after mem_req first rises, logs every access.
    always begin
        @(posedge clk);
        #2;
        auto_ack = 1'b0;
        if (reset) begin
            wait_cnt = 0;
            req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev) begin
                if (acc_cnt < 64) begin
                    log_a[acc_cnt]  = mem_a;
                    log_we[acc_cnt] = mem_we;
                end
                acc_cnt++;
                wait_cnt = 0;
            end
            if (mem_req) begin
                if (wait_cnt == mem_lat) auto_ack = 1'b1;
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
            req_prev = mem_req;
        end
        mem_ack   = (auto_ack && resp_en) || force_ack;
        mem_rdata = mem_ack ? mem_model(mem_a) : 8'hEE;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mreq_n, input logic rd_n, input logic wr_n,
                                 input logic [15:0] a, input logic [7:0] d);
        cpu_mreq_n = mreq_n;
        cpu_rd_n   = rd_n;
        cpu_wr_n   = wr_n;
        cpu_a      = a;
        cpu_do     = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] logged_a(input int idx);
        return (idx < 64) ? log_a[idx] : 16'hXXXX;
    endfunction

    initial begin
        int   base;
        int   low_cnt;
        int   cpu_phase;
        logic done;

        // Reset state
        tick();
        tick();
        #2;
        checkOutput("rst_mem_req",   32'(mem_req),    32'h0);
        checkOutput("rst_mem_we",    32'(mem_we),     32'h0);
        checkOutput("rst_mem_a",     32'(mem_a),      32'h0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata),  32'h0);
        checkOutput("rst_dma_ack",   32'(dma_ack),    32'h0);
        checkOutput("rst_dma_rdata", 32'(dma_rdata),  32'h0);
        checkOutput("rst_cpu_di",    32'(cpu_di),     32'h0);
        checkOutput("rst_wait_n",    32'(cpu_wait_n), 32'h1);
        tick();
        reset = 1'b0;
        tick();

        // CPU read alone, memory acks 3 cycles after mem_req
        $display("[TB] CPU read 0xC123, latency 3");
        mem_lat = 3;
        base = acc_cnt;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hC123, 8'h00);
        #2;
        checkOutput("t1_wait_low_at_strobe", 32'(cpu_wait_n), 32'h0);
        low_cnt = 1;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            #2;
            if (cpu_wait_n) begin
                done = 1'b1;
                break;
            end
            low_cnt++;
        end
        checkOutput("t1_wait_released", 32'(done),    32'h1);
        checkOutput("t1_wait_low_cycles", 32'(low_cnt), 32'd5);
        checkOutput("t1_cpu_di",   32'(cpu_di), 32'h5A);
        checkOutput("t1_mem_a",    32'(logged_a(base)), 32'hC123);
        checkOutput("t1_mem_we",   32'(log_we[base]), 32'h0);
        tick();
        tick();
        #2;
        checkOutput("t1_single_access", 32'(acc_cnt - base), 32'd1);
        checkOutput("t1_wait_stays_high", 32'(cpu_wait_n), 32'h1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick();

        // CPU write alone, zero-wait memory
        $display("[TB] CPU write 0xFF80 <= 0x77, latency 0");
        mem_lat = 0;
        base = acc_cnt;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hFF80, 8'h77);
        #2;
        checkOutput("t2_wait_low_n", 32'(cpu_wait_n), 32'h0);
        tick();
        #2;
        checkOutput("t2_wait_low_n1", 32'(cpu_wait_n), 32'h0);
        checkOutput("t2_mem_req",   32'(mem_req),   32'h1);
        checkOutput("t2_mem_we",    32'(mem_we),    32'h1);
        checkOutput("t2_mem_a",     32'(mem_a),     32'hFF80);
        checkOutput("t2_mem_wdata", 32'(mem_wdata), 32'h77);
        tick();
        #2;
        checkOutput("t2_wait_high_n2", 32'(cpu_wait_n), 32'h1);
        tick();
        tick();
        tick();
        #2;
        checkOutput("t2_single_access", 32'(acc_cnt - base), 32'd1);
        checkOutput("t2_cpu_di_kept",   32'(cpu_di), 32'h5A);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick();

        // Simultaneous CPU read and DMA read, DMA wins
        $display("[TB] simultaneous CPU read 0xD000 / DMA read 0xFE00");
        mem_lat = 1;
        base = acc_cnt;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hD000, 8'h00);
        dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'hFE00; dma_wdata = 8'h00;
        #2;
        checkOutput("t3_wait_low", 32'(cpu_wait_n), 32'h0);
        tick();
        #2;
        checkOutput("t3_first_is_dma", 32'(mem_a), 32'hFE00);
        checkOutput("t3_first_we",     32'(mem_we), 32'h0);
        tick();
        tick();
        if (dma_ack) dma_req = 1'b0;
        #2;
        checkOutput("t3_dma_ack",     32'(dma_ack),   32'h1);
        checkOutput("t3_dma_rdata",   32'(dma_rdata), 32'h46);
        checkOutput("t3_cpu_di_safe", 32'(cpu_di),    32'h5A);
        checkOutput("t3_cpu_waiting", 32'(cpu_wait_n), 32'h0);
        tick();
        dma_req = 1'b0;
        #2;
        checkOutput("t3_dma_ack_pulse", 32'(dma_ack), 32'h0);
        checkOutput("t3_second_is_cpu", 32'(mem_a),   32'hD000);
        checkOutput("t3_cpu_req",       32'(mem_req), 32'h1);
        tick();
        tick();
        #2;
        checkOutput("t3_cpu_released", 32'(cpu_wait_n), 32'h1);
        checkOutput("t3_cpu_di",       32'(cpu_di),     32'h68);
        checkOutput("t3_access_count", 32'(acc_cnt - base), 32'd2);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick();
        tick();

        // Continuous DMA with CPU pending: four DMA grants, then the CPU
        $display("[TB] starvation limit with continuous DMA");
        mem_lat = 0;
        base = acc_cnt;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h8000, 8'h00);
        dma_req = 1'b1; dma_we = 1'b1; dma_a = 16'hFE10; dma_wdata = 8'hAB;
        cpu_phase = 0;
        for (int c = 0; c < 26; c++) begin
            tick();
            if (cpu_phase == 0 && cpu_wait_n) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
                cpu_phase = 1;
            end else if (cpu_phase == 1) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 16'h8001, 8'h00);
                cpu_phase = 2;
            end else if (cpu_phase == 2 && cpu_wait_n) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
                cpu_phase = 3;
            end
        end
        dma_req = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        for (int c = 0; c < 4; c++) tick();
        #2;
        checkOutput("t4_cpu_served_twice", 32'(cpu_phase), 32'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_dma_grant_%0d", i), 32'(logged_a(base + i)), 32'hFE10);
        end
        checkOutput("t4_dma_write", 32'(log_we[base]), 32'h1);
        checkOutput("t4_cpu_after_limit", 32'(logged_a(base + 4)), 32'h8000);
        for (int i = 5; i < 10; i++) begin
            checkOutput($sformatf("t4_dma_resume_%0d", i), 32'(logged_a(base + i)), 32'hFE10);
        end
        checkOutput("t4_cpu_second", 32'(logged_a(base + 10)), 32'h8001);

        // CPU strobe aborted while DMA owns the memory
        $display("[TB] CPU strobe aborted during DMA access");
        mem_lat = 4;
        base = acc_cnt;
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'hFE20;
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h9000, 8'h00);
        #2;
        checkOutput("t5_wait_low", 32'(cpu_wait_n), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        #2;
        checkOutput("t5_wait_high_after_abort", 32'(cpu_wait_n), 32'h1);
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dma_ack) begin
                dma_req = 1'b0;
                done = 1'b1;
                #2;
                checkOutput("t5_dma_rdata", 32'(dma_rdata), 32'h66);
                break;
            end
        end
        checkOutput("t5_dma_ack_seen", 32'(done), 32'h1);
        dma_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        #2;
        checkOutput("t5_no_cpu_access", 32'(acc_cnt - base), 32'd1);
        checkOutput("t5_only_dma_addr", 32'(logged_a(base)), 32'hFE20);

        // Reset in the middle of a DMA access, then a stray late ack
        $display("[TB] reset during DMA access");
        resp_en = 1'b0;
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_a = 16'hFE30;
        tick();
        #2;
        checkOutput("t6_req_before_reset", 32'(mem_req), 32'h1);
        tick();
        reset = 1'b1;
        dma_req = 1'b0;
        #2;
        checkOutput("t6_req_in_reset_cycle", 32'(mem_req), 32'h1);
        tick();
        reset = 1'b0;
        #2;
        checkOutput("t6_req_dropped", 32'(mem_req), 32'h0);
        checkOutput("t6_no_dma_ack",  32'(dma_ack), 32'h0);
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        #2;
        checkOutput("t6_late_ack_no_dma_ack", 32'(dma_ack),   32'h0);
        checkOutput("t6_dma_rdata_cleared",   32'(dma_rdata), 32'h0);
        checkOutput("t6_cpu_di_cleared",      32'(cpu_di),    32'h0);
        checkOutput("t6_still_idle",          32'(mem_req),   32'h0);
        resp_en = 1'b1;
        mem_lat = 0;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hC123, 8'h00);
        #2;
        checkOutput("t6_post_wait_low", 32'(cpu_wait_n), 32'h0);
        tick();
        #2;
        checkOutput("t6_post_mem_a", 32'(mem_a), 32'hC123);
        tick();
        #2;
        checkOutput("t6_post_wait_high", 32'(cpu_wait_n), 32'h1);
        checkOutput("t6_post_cpu_di",    32'(cpu_di),     32'h5A);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
